// File: rtl/l1_trigger_wb_arbiter.sv
// -----------------------------------------------------------------------------
// l1_trigger_wb_arbiter
//
// Round-robin Wishbone arbiter that shares the single L1 trigger interconnect
// target port (15-bit address, 32-bit data) between NUM_HOSTS requesters.
// Only one transaction is outstanding at a time. Every downstream signal comes
// straight from a flop, so there is no combinational path from a host to the
// downstream port.
//
// Optional feature: define L1_ARB_TIMEOUT_EN to add a watchdog. If a downstream
// access is not answered within TIMEOUT_CYCLES WAIT cycles, it ends as an error
// to the owning host with read data 32'hDEADBEEF. Without the macro, WAIT holds
// until the target answers.
//
// Ports
//   wb_clk_i, wb_rst_ni       clock; asynchronous active-low reset
//   host_cyc_i/stb_i/we_i     per-host Wishbone request; request = cyc & stb
//   host_adr_i/dat_i/sel_i    per-host fields, host i at [15*i], [32*i], [4*i]
//   host_ack_o/err_o          per-host one-cycle response pulse
//   host_rty_o                always 0
//   host_dat_o                shared read data, valid with ack/err and held
//                             until the next response
//   wb_*_o / wb_*_i           downstream Wishbone target port
//   grant_o                   one-hot owner; 0 while idle
//   busy_o                    1 while a transaction is in progress
//   dbg_state_o               FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Handshake: a host raises cyc&stb and holds its fields stable until it sees
// its ack/err pulse. Requests are sampled only in IDLE. A host that drops cyc
// before its response loses that response. The downstream cycle still runs to
// completion, because a Wishbone access cannot be aborted.
// -----------------------------------------------------------------------------
module l1_trigger_wb_arbiter #(
   parameter int NUM_HOSTS      = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_ni,
   input  logic [NUM_HOSTS-1:0]      host_cyc_i,
   input  logic [NUM_HOSTS-1:0]      host_stb_i,
   input  logic [NUM_HOSTS-1:0]      host_we_i,
   input  logic [NUM_HOSTS*15-1:0]   host_adr_i,
   input  logic [NUM_HOSTS*32-1:0]   host_dat_i,
   input  logic [NUM_HOSTS*4-1:0]    host_sel_i,
   output logic [NUM_HOSTS-1:0]      host_ack_o,
   output logic [NUM_HOSTS-1:0]      host_err_o,
   output logic [NUM_HOSTS-1:0]      host_rty_o,
   output logic [31:0]               host_dat_o,
   output logic                      wb_cyc_o,
   output logic                      wb_stb_o,
   output logic                      wb_we_o,
   output logic [14:0]               wb_adr_o,
   output logic [31:0]               wb_dat_o,
   output logic [3:0]                wb_sel_o,
   input  logic                      wb_ack_i,
   input  logic                      wb_err_i,
   input  logic [31:0]               wb_dat_i,
   output logic [NUM_HOSTS-1:0]      grant_o,
   output logic                      busy_o,
   output logic [1:0]                dbg_state_o
);

   localparam int PW = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_HOSTS-1:0]   req;
   logic [PW-1:0]          rr_q, owner_q, pick_idx;
   logic                   pick_valid;
   logic                   pick_we;
   logic [14:0]            pick_adr;
   logic [31:0]            pick_dat;
   logic [3:0]             pick_sel;
   logic                   abort_q, owner_lost, bus_done, timeout_hit;

   logic                   wb_cyc_q, wb_we_q;
   logic [14:0]            wb_adr_q;
   logic [31:0]            wb_dat_q, rdat_q;
   logic [3:0]             wb_sel_q;
   logic [NUM_HOSTS-1:0]   grant_q, ack_q, err_q;

   assign req = host_cyc_i & host_stb_i;

   // Scan from the highest offset down, so the requester nearest the
   // round-robin pointer is the one assigned last and wins.
   always_comb begin : pick_owner
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int k = NUM_HOSTS - 1; k >= 0; k--) begin
         if (req[(int'(rr_q) + k) % NUM_HOSTS]) begin
            pick_valid = 1'b1;
            pick_idx   = PW'((int'(rr_q) + k) % NUM_HOSTS);
         end
      end
   end

   always_comb begin : pick_fields
      pick_we  = 1'b0;
      pick_adr = '0;
      pick_dat = '0;
      pick_sel = '0;
      for (int i = 0; i < NUM_HOSTS; i++) begin
         if (pick_idx == PW'(i)) begin
            pick_we  = host_we_i[i];
            pick_adr = host_adr_i[15*i +: 15];
            pick_dat = host_dat_i[32*i +: 32];
            pick_sel = host_sel_i[4*i +: 4];
         end
      end
   end

   // A response is delivered only if the owner kept cyc high for the whole
   // access, including the cycle in which the access completes.
   assign owner_lost = abort_q | ~host_cyc_i[owner_q];
   assign bus_done   = wb_ack_i | wb_err_i;

`ifdef L1_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt_q;

   // The count is 0 in the first WAIT cycle. When it reaches
   // TIMEOUT_CYCLES-1, that is the last WAIT cycle allowed.
   assign timeout_hit = (state_q == S_WAIT) && !bus_done &&
                        (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         tmo_cnt_q <= '0;
      end else if (state_q == S_ISSUE) begin
         tmo_cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
`else
   // No watchdog in this build. This expression is constant false. It refers
   // to TIMEOUT_CYCLES so that both builds share one parameter list.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick_valid) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (bus_done || timeout_hit) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= S_IDLE;
         rr_q     <= '0;
         owner_q  <= '0;
         abort_q  <= 1'b0;
         wb_cyc_q <= 1'b0;
         wb_we_q  <= 1'b0;
         wb_adr_q <= '0;
         wb_dat_q <= '0;
         wb_sel_q <= '0;
         grant_q  <= '0;
         ack_q    <= '0;
         err_q    <= '0;
         rdat_q   <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= '0;
         err_q   <= '0;
         case (state_q)
            S_IDLE: begin
               if (pick_valid) begin
                  owner_q  <= pick_idx;
                  wb_cyc_q <= 1'b1;
                  wb_we_q  <= pick_we;
                  wb_adr_q <= pick_adr;
                  wb_dat_q <= pick_dat;
                  wb_sel_q <= pick_sel;
                  grant_q  <= NUM_HOSTS'(1) << pick_idx;
                  abort_q  <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (owner_lost) abort_q <= 1'b1;
            end
            S_WAIT: begin
               if (owner_lost) abort_q <= 1'b1;
               if (bus_done) begin
                  // If ack and err arrive together, err wins.
                  wb_cyc_q <= 1'b0;
                  if (!owner_lost) begin
                     ack_q[owner_q] <= wb_ack_i & ~wb_err_i;
                     err_q[owner_q] <= wb_err_i;
                     rdat_q         <= wb_we_q ? 32'h0 : wb_dat_i;
                  end
               end else if (timeout_hit) begin
                  wb_cyc_q <= 1'b0;
                  if (!owner_lost) begin
                     err_q[owner_q] <= 1'b1;
                     rdat_q         <= 32'hDEAD_BEEF;
                  end
               end
            end
            S_RESP: begin
               grant_q <= '0;
               rr_q    <= (owner_q == PW'(NUM_HOSTS - 1)) ? '0 : owner_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign wb_cyc_o    = wb_cyc_q;
   assign wb_stb_o    = wb_cyc_q;
   assign wb_we_o     = wb_we_q;
   assign wb_adr_o    = wb_adr_q;
   assign wb_dat_o    = wb_dat_q;
   assign wb_sel_o    = wb_sel_q;
   assign host_ack_o  = ack_q;
   assign host_err_o  = err_q;
   assign host_rty_o  = '0;
   assign host_dat_o  = rdat_q;
   assign grant_o     = grant_q;
   assign busy_o      = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_l1_trigger_wb_arbiter.sv
module tb_l1_trigger_wb_arbiter;
   localparam int N = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0]    host_cyc, host_stb, host_we;
   logic [N*15-1:0] host_adr;
   logic [N*32-1:0] host_dat;
   logic [N*4-1:0]  host_sel;
   logic [N-1:0]    host_ack, host_err, host_rty, grant;
   logic [31:0]     host_rdat;
   logic            wb_cyc, wb_stb, wb_we, wb_ack, wb_err, busy;
   logic [14:0]     wb_adr;
   logic [31:0]     wb_wdat, wb_rdat;
   logic [3:0]      wb_sel;
   logic [1:0]      dbg_state;

   l1_trigger_wb_arbiter #(.NUM_HOSTS(N), .TIMEOUT_CYCLES(16)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .host_cyc_i(host_cyc), .host_stb_i(host_stb), .host_we_i(host_we),
      .host_adr_i(host_adr), .host_dat_i(host_dat), .host_sel_i(host_sel),
      .host_ack_o(host_ack), .host_err_o(host_err), .host_rty_o(host_rty),
      .host_dat_o(host_rdat),
      .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
      .wb_dat_o(wb_wdat), .wb_sel_o(wb_sel),
      .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_dat_i(wb_rdat),
      .grant_o(grant), .busy_o(busy), .dbg_state_o(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int tests_run = 0;
   int tests_failed = 0;
   logic [31:0] exp_q[$];
   int mdl_ptr = 0;   // reference round-robin pointer

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference arbitration: first requester at or after the pointer, wrapping.
   function automatic int model_pick(input logic [N-1:0] mask);
      for (int k = 0; k < N; k++)
         if (mask[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
      return -1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_reqs();
      host_cyc = '0; host_stb = '0; host_we = '0;
      host_adr = '0; host_dat = '0; host_sel = '0;
   endtask

   task automatic set_req(input int h, input bit we, input logic [14:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
      host_cyc[h] = 1'b1; host_stb[h] = 1'b1; host_we[h] = we;
      host_adr[15*h +: 15] = adr;
      host_dat[32*h +: 32] = dat;
      host_sel[4*h +: 4]   = sel;
   endtask

   // Count falling edges until wb_cyc_o is seen; a bounded wait.
   task automatic wait_cyc(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!wb_cyc && n < 20);
      if (!wb_cyc) check("wait_cyc_timeout", 0, 1);
   endtask

   // Called on the falling edge where cyc is first seen. The target answers
   // `delay` cycles later; this returns on the falling edge of the response cycle.
   task automatic slave_respond(input int delay, input bit err, input logic [31:0] rdata);
      repeat (delay) @(negedge clk);
      check("cyc_held", wb_cyc, 1);
      wb_ack = !err; wb_err = err; wb_rdat = rdata;
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0; wb_rdat = $urandom;
   endtask

   // Complete one isolated transaction from an idle arbiter.
   task automatic run_txn(input int h, input bit we, input logic [14:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input int delay, input bit err,
                          input logic [31:0] rdata, input logic [31:0] exp_dat);
      int n;
      logic [N-1:0] onehot;
      onehot = '0; onehot[h] = 1'b1;
      set_req(h, we, adr, dat, sel);
      wait_cyc(n);
      check("issue_latency", n, 1);
      check("grant", grant, onehot);
      check("wb_adr", wb_adr, adr);
      check("wb_we", wb_we, we);
      check("wb_wdat", wb_wdat, dat);
      check("wb_sel", wb_sel, sel);
      check("wb_stb", wb_stb, 1);
      slave_respond(delay, err, rdata);
      check("host_ack", host_ack, err ? '0 : onehot);
      check("host_err", host_err, err ? onehot : '0);
      check("host_dat", host_rdat, exp_dat);
      check("cyc_drop_after_ack", wb_cyc, 0);
      clear_reqs();
      mdl_ptr = (h + 1) % N;
      @(negedge clk);
      check("ack_single_pulse", host_ack | host_err, 0);
      check("idle_busy", busy, 0);
      check("idle_grant", grant, 0);
      check("dat_held", host_rdat, exp_dat);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          h;
      bit          we;
      logic [14:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          delay;
      bit          err;
      logic [31:0] rdata;
      logic [31:0] exp_dat;
   } vec_t;
   vec_t vecs[5];

   // ---------------- main sequence ----------------
   initial begin
      int n, g, got;
      int grants[$];
      logic [N-1:0] mask;
      logic [14:0]  r_adr[N];
      logic         r_we[N];
      logic [31:0]  r_dat;
      bit           r_err;

      vecs[0] = '{0, 1'b1, 15'h2004, 32'h1234_5678, 4'hF, 3, 1'b0, 32'h5555_AAAA, 32'h0};
      vecs[1] = '{1, 1'b0, 15'h6010, 32'h0,         4'hF, 2, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vecs[2] = '{2, 1'b1, 15'h7FFF, 32'hFFFF_FFFF, 4'h5, 1, 1'b1, 32'h1111_1111, 32'h0};
      vecs[3] = '{0, 1'b0, 15'h0000, 32'h0,         4'h3, 5, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
      vecs[4] = '{2, 1'b0, 15'h1234, 32'h0,         4'h8, 1, 1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F};

      rst_n = 1'b0;
      clear_reqs();
      wb_ack = 1'b0; wb_err = 1'b0; wb_rdat = '0;
      repeat (2) @(negedge clk);
      check("rst_cyc", wb_cyc, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_hdat", host_rdat, 0);
      check("rst_ack", host_ack | host_err | host_rty, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven single transactions
      for (int i = 0; i < 5; i++)
         run_txn(vecs[i].h, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                 vecs[i].delay, vecs[i].err, vecs[i].rdata, vecs[i].exp_dat);

      // Downstream ack while idle must be ignored
      wb_ack = 1'b1; wb_rdat = 32'h9999_9999;
      @(negedge clk);
      wb_ack = 1'b0;
      check("stray_ack_busy", busy, 0);
      @(negedge clk);
      check("stray_ack_host", host_ack | host_err, 0);
      check("stray_ack_dat", host_rdat, 32'h0F0F_0F0F);

      // Hosts 0 and 1 request continuously: round-robin alternation
      set_req(0, 1'b0, 15'h0100, 32'h0, 4'hF);
      set_req(1, 1'b0, 15'h0200, 32'h0, 4'hF);
      wb_rdat = '0;
      for (int c = 0; c < 200 && grants.size() < 6; c++) begin
         @(negedge clk);
         if (host_ack != '0) begin
            for (int b = 0; b < N; b++) if (host_ack[b]) grants.push_back(b);
         end
         wb_ack = wb_cyc && !wb_ack;
      end
      wb_ack = 1'b0;
      clear_reqs();
      check("rr_count", grants.size(), 6);
      for (int i = 0; i < grants.size(); i++) begin
         g = model_pick(3'b011);
         check("rr_order", grants[i], g);
         if (i > 0) check("rr_no_repeat", grants[i] == grants[i-1], 0);
         mdl_ptr = (g + 1) % N;
      end
      repeat (2) @(negedge clk);

      // Randomized contention against the reference model
      for (int r = 0; r < 40; r++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int h = 0; h < N; h++) begin
            r_adr[h] = 15'($urandom);
            r_we[h]  = 1'($urandom);
            if (mask[h]) set_req(h, r_we[h], r_adr[h], $urandom, 4'($urandom));
         end
         g = model_pick(mask);
         wait_cyc(n);
         check("rnd_latency", n, 1);
         check("rnd_grant", grant, N'(1) << g);
         check("rnd_adr", wb_adr, r_adr[g]);
         check("rnd_we", wb_we, r_we[g]);
         r_dat = $urandom;
         r_err = ($urandom_range(0, 3) == 0);
         exp_q.push_back(r_we[g] ? 32'h0 : r_dat);
         slave_respond($urandom_range(1, 4), r_err, r_dat);
         check("rnd_ack", host_ack, r_err ? '0 : N'(1) << g);
         check("rnd_err", host_err, r_err ? N'(1) << g : '0);
         check("rnd_dat", host_rdat, exp_q.pop_front());
         clear_reqs();
         mdl_ptr = (g + 1) % N;
         @(negedge clk);
      end

      // Reset during WAIT: outputs clear without a clock edge, pointer returns to 0
      run_txn(0, 1'b0, 15'h0040, 32'h0, 4'hF, 1, 1'b0, 32'h1111_2222, 32'h1111_2222);
      set_req(1, 1'b1, 15'h0044, 32'hABCD_0000, 4'hF);
      wait_cyc(n);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_cyc", wb_cyc, 0);
      check("async_rst_grant", grant, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_hdat", host_rdat, 0);
      clear_reqs();
      @(negedge clk);
      check("rst_no_pulse", host_ack | host_err, 0);
      rst_n = 1'b1;
      mdl_ptr = 0;

      // Owner 0 drops cyc in WAIT; host 1 is pending and must be served next
      set_req(0, 1'b1, 15'h0300, 32'h0000_00AA, 4'hF);
      set_req(1, 1'b0, 15'h0304, 32'h0, 4'hF);
      wait_cyc(n);
      check("post_rst_priority", grant, 3'b001);
      @(negedge clk);
      host_cyc[0] = 1'b0; host_stb[0] = 1'b0;
      @(negedge clk);
      check("abort_cyc_held", wb_cyc, 1);
      wb_ack = 1'b1; wb_rdat = 32'h7777_7777;
      @(negedge clk);
      wb_ack = 1'b0;
      check("abort_no_ack", host_ack | host_err, 0);
      check("abort_cyc_drop", wb_cyc, 0);
      wait_cyc(n);
      check("abort_next_grant", grant, 3'b010);
      slave_respond(2, 1'b0, 32'h0BAD_CAFE);
      check("abort_next_ack", host_ack, 3'b010);
      check("abort_next_dat", host_rdat, 32'h0BAD_CAFE);
      clear_reqs();
      @(negedge clk);

`ifdef L1_ARB_TIMEOUT_EN
      // Target never answers: error after 16 WAIT cycles
      set_req(2, 1'b0, 15'h0500, 32'h0, 4'hF);
      wait_cyc(n);
      n = 0;
      while (host_err == '0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("tmo_cycles", n, 17);
      check("tmo_err", host_err, 3'b100);
      check("tmo_dat", host_rdat, 32'hDEAD_BEEF);
      check("tmo_cyc_drop", wb_cyc, 0);
      clear_reqs();
      @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #300000;
      tests_failed++;
      $display("FAIL global_timeout: simulation did not finish, run stopped");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
